// File: rtl/cpu_trace_checker.sv
// Recognises "^time@pc: $grf <= data#" and "^time@pc: *addr <= data#" trace lines and range-checks their fields.
// Optional feature macro: CPU_TRACE_LINE_COUNT_EN adds a saturating accepted-line counter (line_count).
module cpu_trace_checker #(
    parameter int unsigned TIME_DIGITS = 4,
    parameter int unsigned GRF_DIGITS  = 4,
    parameter logic [31:0] TIME_MAX    = 32'd4095,
    parameter logic [31:0] PC_LO       = 32'h0000_3000,
    parameter logic [31:0] PC_HI       = 32'h0000_4fff,
    parameter logic [31:0] ADDR_HI     = 32'h0000_2fff
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] char,
    output logic [1:0] format_type,
    output logic [3:0] error_code
`ifdef CPU_TRACE_LINE_COUNT_EN
    ,
    output logic [15:0] line_count
`endif
);

    typedef enum logic [3:0] {
        S_IDLE, S_TIME, S_PC, S_COLON, S_SP1, S_GRF, S_ADDR,
        S_SP2, S_LT, S_SP3, S_DATA, S_HASH
    } state_t;

    localparam logic [3:0] TD = 4'(TIME_DIGITS);
    localparam logic [3:0] GD = 4'(GRF_DIGITS);

    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic [31:0] time_acc, time_n;
    logic [31:0] pc_acc, pc_n;
    logic [31:0] addr_acc, addr_n;
    logic [15:0] grf_acc, grf_n;
    logic        is_mem, is_mem_n;
    logic        accept, restart, go_idle;

    function automatic logic is_dec(input logic [7:0] c);
        return (c >= "0") && (c <= "9");
    endfunction

    function automatic logic is_hex(input logic [7:0] c);
        return is_dec(c) || ((c >= "a") && (c <= "f"));
    endfunction

    function automatic logic [3:0] hex_val(input logic [7:0] c);
        return is_dec(c) ? c[3:0] : c[3:0] + 4'd9;
    endfunction

    function automatic logic [3:0] range_err(input logic        mem,
                                             input logic [31:0] t,
                                             input logic [31:0] pc,
                                             input logic [31:0] addr,
                                             input logic [15:0] grf);
        logic [3:0] e;
        e[0] = t > TIME_MAX;
        e[1] = (pc[1:0] != 2'd0) || (pc < PC_LO) || (pc > PC_HI);
        e[2] = mem && ((addr[1:0] != 2'd0) || (addr > ADDR_HI));
        e[3] = !mem && (grf > 16'd31);
        return e;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hffff) ? v : v + 16'd1;
    endfunction

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        time_n   = time_acc;
        pc_n     = pc_acc;
        addr_n   = addr_acc;
        grf_n    = grf_acc;
        is_mem_n = is_mem;
        accept   = 1'b0;
        go_idle  = 1'b0;
        restart  = (char == "^");

        if (!restart) begin
            case (state)
                S_IDLE: ;
                S_TIME:
                    if (is_dec(char) && (cnt < TD)) begin
                        time_n = time_acc * 32'd10 + {28'd0, char[3:0]};
                        cnt_n  = cnt + 4'd1;
                    end else if ((char == "@") && (cnt != 4'd0)) begin
                        state_n = S_PC;
                        cnt_n   = 4'd0;
                    end else go_idle = 1'b1;
                S_PC:
                    if (is_hex(char)) begin
                        pc_n  = {pc_acc[27:0], hex_val(char)};
                        cnt_n = (cnt == 4'd7) ? 4'd0 : cnt + 4'd1;
                        if (cnt == 4'd7) state_n = S_COLON;
                    end else go_idle = 1'b1;
                S_COLON:
                    if (char == ":") state_n = S_SP1;
                    else go_idle = 1'b1;
                S_SP1:
                    if (char == "$") begin
                        state_n  = S_GRF;
                        is_mem_n = 1'b0;
                    end else if (char == "*") begin
                        state_n  = S_ADDR;
                        is_mem_n = 1'b1;
                    end else if (char != " ") go_idle = 1'b1;
                S_GRF:
                    if (is_dec(char) && (cnt < GD)) begin
                        grf_n = grf_acc * 16'd10 + {12'd0, char[3:0]};
                        cnt_n = cnt + 4'd1;
                    end else if ((char == " ") && (cnt != 4'd0)) begin
                        state_n = S_SP2;
                        cnt_n   = 4'd0;
                    end else if ((char == "<") && (cnt != 4'd0)) begin
                        // '<' directly after the digits doubles as the LT token
                        state_n = S_LT;
                        cnt_n   = 4'd0;
                    end else go_idle = 1'b1;
                S_ADDR:
                    if (is_hex(char)) begin
                        addr_n = {addr_acc[27:0], hex_val(char)};
                        cnt_n  = (cnt == 4'd7) ? 4'd0 : cnt + 4'd1;
                        if (cnt == 4'd7) state_n = S_SP2;
                    end else go_idle = 1'b1;
                S_SP2:
                    if (char == "<") state_n = S_LT;
                    else if (char != " ") go_idle = 1'b1;
                S_LT:
                    if (char == "=") state_n = S_SP3;
                    else go_idle = 1'b1;
                S_SP3:
                    if (is_hex(char)) begin
                        state_n = S_DATA;
                        cnt_n   = 4'd1;
                    end else if (char != " ") go_idle = 1'b1;
                S_DATA:
                    if (is_hex(char)) begin
                        cnt_n = (cnt == 4'd7) ? 4'd0 : cnt + 4'd1;
                        if (cnt == 4'd7) state_n = S_HASH;
                    end else go_idle = 1'b1;
                S_HASH: begin
                    accept  = (char == "#");
                    go_idle = 1'b1;
                end
                default: go_idle = 1'b1;
            endcase
        end

        if (restart || go_idle) begin
            state_n  = restart ? S_TIME : S_IDLE;
            cnt_n    = 4'd0;
            time_n   = 32'd0;
            pc_n     = 32'd0;
            addr_n   = 32'd0;
            grf_n    = 16'd0;
            is_mem_n = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt         <= 4'd0;
            time_acc    <= 32'd0;
            pc_acc      <= 32'd0;
            addr_acc    <= 32'd0;
            grf_acc     <= 16'd0;
            is_mem      <= 1'b0;
            format_type <= 2'b00;
            error_code  <= 4'd0;
        end else begin
            cnt         <= cnt_n;
            time_acc    <= time_n;
            pc_acc      <= pc_n;
            addr_acc    <= addr_n;
            grf_acc     <= grf_n;
            is_mem      <= is_mem_n;
            format_type <= accept ? (is_mem ? 2'b10 : 2'b01) : 2'b00;
            error_code  <= accept ? range_err(is_mem, time_acc, pc_acc, addr_acc, grf_acc) : 4'd0;
        end
    end

`ifdef CPU_TRACE_LINE_COUNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)       line_count <= 16'd0;
        else if (accept) line_count <= sat_inc(line_count);
    end
`endif

endmodule

// File: tb/tb_cpu_trace_checker.sv
// Randomised and directed bench for cpu_trace_checker, with a field-level reference model.
module tb_cpu_trace_checker;

    localparam logic [31:0] TIME_MAX = 32'd4095;
    localparam logic [31:0] PC_LO    = 32'h0000_3000;
    localparam logic [31:0] PC_HI    = 32'h0000_4fff;
    localparam logic [31:0] ADDR_HI  = 32'h0000_2fff;

    logic       clk;
    logic       reset;
    logic [7:0] char;
    logic [1:0] format_type;
    logic [3:0] error_code;
`ifdef CPU_TRACE_LINE_COUNT_EN
    logic [15:0] line_count;
`endif

    int n_pass  = 0;
    int n_total = 0;
    logic [5:0] obs_q[$];

    cpu_trace_checker dut (
        .clk         (clk),
        .reset       (reset),
        .char        (char),
        .format_type (format_type),
        .error_code  (error_code)
`ifdef CPU_TRACE_LINE_COUNT_EN
        ,
        .line_count  (line_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: expected {format_type, error_code} for a well-formed line with these field values
    function automatic logic [5:0] model(input bit mem, input int unsigned t, input logic [31:0] pc,
                                         input logic [31:0] addr, input int unsigned grf);
        logic [3:0] e;
        e[0] = t > TIME_MAX;
        e[1] = (pc % 4 != 0) || (pc < PC_LO) || (pc > PC_HI);
        e[2] = mem && ((addr % 4 != 0) || (addr > ADDR_HI));
        e[3] = !mem && (grf > 31);
        return {(mem ? 2'b10 : 2'b01), e};
    endfunction

    function automatic string spaces(input int n);
        string r = "";
        for (int i = 0; i < n; i++) r = {r, " "};
        return r;
    endfunction

    task automatic feed(input string s);
        obs_q.delete();
        for (int i = 0; i < s.len(); i++) begin
            @(negedge clk);
            char = s[i];
            @(posedge clk);
            #1;
            obs_q.push_back({format_type, error_code});
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        char  = 8'h00;
        repeat (2) @(negedge clk);
        n_total++;
        if ({format_type, error_code} !== 6'd0)
            $display("FAIL reset_outputs got %b expected 000000", {format_type, error_code});
        else n_pass++;
`ifdef CPU_TRACE_LINE_COUNT_EN
        n_total++;
        if (line_count !== 16'd0) $display("FAIL reset_count got %0d expected 0", line_count);
        else n_pass++;
`endif
        reset = 1'b0;
    endtask

    task automatic test_directed;
        string      s[9];
        logic [5:0] e[9];
        logic [5:0] exp;
        s[0] = "^42@00003004: $28 <= ff00ff00#";            e[0] = 6'b01_0000;
        s[1] = "^1@00003000: *00000010 <= 12345678#";       e[1] = 6'b10_0000;
        s[2] = "^1@00003002: *00000010 <= 12345678#";       e[2] = 6'b10_0010;
        s[3] = "^5000@00003000: $40 <= 00000000#";          e[3] = 6'b01_1001;
        s[4] = "^0@00004ffc: *00003000 <= 00000000#";       e[4] = 6'b10_0100;
        s[5] = "^4095@00004ffc: $31<= 0000abcd#";           e[5] = 6'b01_0000;
        s[6] = "^4096@00002ffc:*00002ffd<=00000000#";       e[6] = 6'b10_0111;
        s[7] = "^7@00005000:   $32   <=   deadbeef#";       e[7] = 6'b01_1010;
        s[8] = "^0007@00003ffc: *00002ffc <= 00000000#";    e[8] = 6'b10_0000;
        for (int k = 0; k < 9; k++) begin
            feed(s[k]);
            for (int i = 0; i < obs_q.size(); i++) begin
                exp = (i == obs_q.size() - 1) ? e[k] : 6'd0;
                n_total++;
                if (obs_q[i] !== exp)
                    $display("FAIL directed_%0d idx %0d got %b expected %b", k, i, obs_q[i], exp);
                else n_pass++;
            end
        end
    endtask

    task automatic test_rejects;
        string s[11];
        s[0]  = "^12345@00003000: $1 <= 00000000#";
        s[1]  = "^1@00003000: $1x <= 00000000#";
        s[2]  = "^1@00003000: $12345 <= 00000000#";
        s[3]  = "^1@0000300A: $1 <= 00000000#";
        s[4]  = "^1@000030000: $1 <= 00000000#";
        s[5]  = "^1@00003000: $1 < = 00000000#";
        s[6]  = "^1@00003000: $1 <= 0000000#";
        s[7]  = "^1@00003000: $1 <= 000000000#";
        s[8]  = "1@00003000: $1 <= 00000000#";
        s[9]  = "^@00003000: $1 <= 00000000#";
        s[10] = "^1@00003000: $<= 00000000#";
        for (int k = 0; k < 11; k++) begin
            feed(s[k]);
            for (int i = 0; i < obs_q.size(); i++) begin
                n_total++;
                if (obs_q[i] !== 6'd0)
                    $display("FAIL reject_%0d idx %0d got %b expected 000000", k, i, obs_q[i]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_restart;
        string      s[2];
        logic [5:0] exp;
        s[0] = "^12@0000^7@00003008:*00000ffc<=0000000a#";
        s[1] = "^1@00003000: $3 <= 12345678^9@00003010: $30 <= 00000001#";
        for (int k = 0; k < 2; k++) begin
            feed(s[k]);
            for (int i = 0; i < obs_q.size(); i++) begin
                exp = (i != obs_q.size() - 1) ? 6'd0 : (k == 0) ? 6'b10_0000 : 6'b01_0000;
                n_total++;
                if (obs_q[i] !== exp)
                    $display("FAIL restart_%0d idx %0d got %b expected %b", k, i, obs_q[i], exp);
                else n_pass++;
            end
        end
    endtask

    task automatic test_back_to_back;
        string      a, b, c;
        logic [5:0] exp;
        int         la, lb;
        a = "^3@00003000: $5 <= 00000000#";
        b = "^9999@00003001: *00000004 <= 11111111#";
        c = "^0@00004ffc: $33 <= 22222222#";
        la = a.len();
        lb = b.len();
        feed({a, b, c});
        for (int i = 0; i < obs_q.size(); i++) begin
            exp = (i == la - 1)           ? 6'b01_0000 :
                  (i == la + lb - 1)      ? 6'b10_0011 :
                  (i == obs_q.size() - 1) ? 6'b01_1000 : 6'd0;
            n_total++;
            if (obs_q[i] !== exp)
                $display("FAIL back_to_back idx %0d got %b expected %b", i, obs_q[i], exp);
            else n_pass++;
        end
    endtask

    task automatic test_reset_midline;
        feed("^42@00003004: $2");
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_total++;
        if ({format_type, error_code} !== 6'd0)
            $display("FAIL reset_mid got %b expected 000000", {format_type, error_code});
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        feed("8 <= ff00ff00#");
        for (int i = 0; i < obs_q.size(); i++) begin
            n_total++;
            if (obs_q[i] !== 6'd0)
                $display("FAIL reset_mid_tail idx %0d got %b expected 000000", i, obs_q[i]);
            else n_pass++;
        end
        // reset asserted while a report is being shown clears it without waiting for a clock
        feed("^5000@00003000: $40 <= 00000000#");
        n_total++;
        if (obs_q[obs_q.size() - 1] !== 6'b01_1001)
            $display("FAIL reset_out_pre got %b expected 011001", obs_q[obs_q.size() - 1]);
        else n_pass++;
        reset = 1'b1;
        #1;
        n_total++;
        if ({format_type, error_code} !== 6'd0)
            $display("FAIL reset_async got %b expected 000000", {format_type, error_code});
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_random;
        string       s, pre, post, bad;
        logic [5:0]  exp, want;
        logic [31:0] pc, addr, data;
        int unsigned t, grf, p;
        bit          mem, corrupt;
        for (int n = 0; n < 150; n++) begin
            t = ($urandom_range(0, 3) == 0) ? $urandom_range(4000, 9999) : $urandom_range(0, 4200);
            case ($urandom_range(0, 6))
                0:       pc = PC_LO;
                1:       pc = PC_HI - 32'd3;
                2:       pc = $urandom_range(PC_LO, PC_HI) & ~32'd3;
                3:       pc = $urandom;
                4:       pc = $urandom_range(PC_LO, PC_HI);
                5:       pc = PC_LO - 32'd4;
                default: pc = PC_HI + 32'd1;
            endcase
            case ($urandom_range(0, 4))
                0:       addr = ADDR_HI - 32'd3;
                1:       addr = ADDR_HI + 32'd1;
                2:       addr = $urandom_range(0, ADDR_HI) & ~32'd3;
                3:       addr = $urandom_range(0, 32'h0000_4000);
                default: addr = $urandom;
            endcase
            grf  = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 9999);
            data = $urandom;
            mem  = $urandom_range(0, 1) == 1;
            if (mem)
                s = $sformatf("^%0d@%08h:%s*%08h%s<=%s%08h#", t, pc, spaces($urandom_range(0, 2)),
                              addr, spaces($urandom_range(0, 2)), spaces($urandom_range(0, 2)), data);
            else
                s = $sformatf("^%0d@%08h:%s$%0d%s<=%s%08h#", t, pc, spaces($urandom_range(0, 2)),
                              grf, spaces($urandom_range(0, 2)), spaces($urandom_range(0, 2)), data);
            want    = model(mem, t, pc, addr, grf);
            corrupt = $urandom_range(0, 3) == 0;
            if (corrupt) begin
                case ($urandom_range(0, 3))
                    0:       bad = "G";
                    1:       bad = "A";
                    2:       bad = "x";
                    default: bad = "!";
                endcase
                p    = $urandom_range(1, s.len() - 1);
                pre  = s.substr(0, p - 1);
                post = s.substr(p, s.len() - 1);
                s    = {pre, bad, post};
            end
            feed(s);
            for (int i = 0; i < obs_q.size(); i++) begin
                exp = (!corrupt && i == obs_q.size() - 1) ? want : 6'd0;
                n_total++;
                if (obs_q[i] !== exp)
                    $display("FAIL random_%0d idx %0d got %b expected %b line %s", n, i, obs_q[i], exp, s);
                else n_pass++;
            end
        end
    endtask

`ifdef CPU_TRACE_LINE_COUNT_EN
    task automatic test_line_count;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        feed({"^1@00003000: $1 <= 00000000#", "^2@00003004: *00000008 <= 00000001#",
              "^9000@00000001: $99 <= 00000002#", "^1@00003000: $1x"});
        n_total++;
        if (line_count !== 16'd3) $display("FAIL line_count got %0d expected 3", line_count);
        else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_total++;
        if (line_count !== 16'd0) $display("FAIL line_count_reset got %0d expected 0", line_count);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
    endtask
`endif

    initial begin
        test_reset;
        test_directed;
        test_rejects;
        test_restart;
        test_back_to_back;
        test_reset_midline;
        test_random;
`ifdef CPU_TRACE_LINE_COUNT_EN
        test_line_count;
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
